// File: rtl/data_buffer_ctrl.sv
// data_buffer_ctrl: single-port arbiter and FIFO pointer owner for the endpoint
// data buffer SRAM shared by the AHB register block and the USB packet engines.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   clear                      flush request; resets pointers and occupancy
//   store_tx_data / tx_data    AHB byte write request (level) and data
//   get_rx_data                AHB byte read request (level)
//   store_rx_packet_data /
//   rx_packet_data             USB RX byte write request (level) and data
//   get_tx_packet_data         USB TX byte read request (level)
//   mem_*                      SRAM strobe, write enable, address, write/read data
//   ahb_grant, ahb_wait        AHB request served / pending-not-served (combinational)
//   usb_grant                  USB request served (combinational)
//   rx_data, rx_data_valid     AHB read byte and valid pulse, one cycle after grant
//   tx_packet_data,
//   tx_data_valid              USB read byte and valid pulse, one cycle after grant
//   buffer_occupancy           bytes currently stored
//   overflow_err/underflow_err one-cycle pulses for writes-when-full / reads-when-empty
module data_buffer_ctrl #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     store_tx_data,
    input  logic [7:0]               tx_data,
    input  logic                     get_rx_data,
    input  logic                     store_rx_packet_data,
    input  logic [7:0]               rx_packet_data,
    input  logic                     get_tx_packet_data,
    input  logic [7:0]               mem_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     ahb_grant,
    output logic                     ahb_wait,
    output logic                     usb_grant,
    output logic [7:0]               rx_data,
    output logic                     rx_data_valid,
    output logic [7:0]               tx_packet_data,
    output logic                     tx_data_valid,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    // ACCESS means the previous cycle really strobed the SRAM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_USB_WR = 3'd1,
        OP_USB_RD = 3'd2,
        OP_AHB_WR = 3'd3,
        OP_AHB_RD = 3'd4
    } op_e;

    state_e        state_q, state_d;
    op_e           op;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_valid_q, tx_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [7:0]    rx_hold_q, tx_hold_q;
    logic [7:0]    rd_byte;
    logic          ahb_req;
    logic          starve_hit;
    logic          full;
    logic          empty;

    assign ahb_req    = store_tx_data | get_rx_data;
    assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
    assign full       = (occ_q == OW'(DEPTH));
    assign empty      = (occ_q == '0);
    assign ahb_wait   = ahb_req & ~ahb_grant;

    // Read returns SRAM data only if the SRAM was actually accessed; an empty read returns 0
    assign rd_byte = (state_q == ACCESS) ? mem_rdata : 8'h00;

    // Data outputs show the fresh byte on the valid cycle and hold it afterwards
    assign rx_data          = rx_valid_q ? rd_byte : rx_hold_q;
    assign tx_packet_data   = tx_valid_q ? rd_byte : tx_hold_q;
    assign rx_data_valid    = rx_valid_q;
    assign tx_data_valid    = tx_valid_q;
    assign buffer_occupancy = occ_q;
    assign overflow_err     = ovf_q;
    assign underflow_err    = udf_q;

    // State, pointers, occupancy and registered output pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            starve_q   <= '0;
            rx_valid_q <= 1'b0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rx_hold_q  <= 8'h00;
            tx_hold_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            starve_q   <= starve_d;
            rx_valid_q <= rx_valid_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rx_hold_q  <= rx_data;
            tx_hold_q  <= tx_packet_data;
        end
    end

    // Arbitration, SRAM access and next-state
    always_comb begin
        state_d    = IDLE;
        op         = OP_NONE;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        starve_d   = starve_q;
        rx_valid_d = 1'b0;
        tx_valid_d = 1'b0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        ahb_grant  = 1'b0;
        usb_grant  = 1'b0;

        if (clear) begin
            state_d  = FLUSH;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            starve_d = '0;
        end else begin
            // A starved AHB side wins exactly one arbitration, then the counter restarts
            if (ahb_req && starve_hit) begin
                op = store_tx_data ? OP_AHB_WR : OP_AHB_RD;
            end else if (store_rx_packet_data) begin
                op = OP_USB_WR;
            end else if (get_tx_packet_data) begin
                op = OP_USB_RD;
            end else if (store_tx_data) begin
                op = OP_AHB_WR;
            end else if (get_rx_data) begin
                op = OP_AHB_RD;
            end

            ahb_grant = (op == OP_AHB_WR) || (op == OP_AHB_RD);
            usb_grant = (op == OP_USB_WR) || (op == OP_USB_RD);

            case (op)
                OP_USB_WR, OP_AHB_WR: begin
                    // Handshake completes even when full; the byte is dropped
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_ptr_q;
                        mem_wdata = (op == OP_USB_WR) ? rx_packet_data : tx_data;
                        wr_ptr_d  = wr_ptr_q + AW'(1);
                        occ_d     = occ_q + OW'(1);
                        state_d   = ACCESS;
                    end
                end
                OP_USB_RD, OP_AHB_RD: begin
                    rx_valid_d = (op == OP_AHB_RD);
                    tx_valid_d = (op == OP_USB_RD);
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = rd_ptr_q;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        occ_d    = occ_q - OW'(1);
                        state_d  = ACCESS;
                    end
                end
                default: ;
            endcase

            if (ahb_grant) begin
                starve_d = '0;
            end else if (ahb_req && !starve_hit) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_buffer_ctrl.sv
// tb_data_buffer_ctrl: scenario-task bench for data_buffer_ctrl with an SRAM
// model, a FIFO reference model and expected-byte queues for the read ports.
module tb_data_buffer_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_en;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       ahb_grant;
    logic       ahb_wait;
    logic       usb_grant;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] tx_packet_data;
    logic       tx_data_valid;
    logic [6:0] buffer_occupancy;
    logic       overflow_err;
    logic       underflow_err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  sram [64];
    logic [7:0]  model_q[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  tx_exp[$];
    int unsigned exp_wr = 0;
    int unsigned exp_rd = 0;
    logic [7:0]  mon_b;

    data_buffer_ctrl #(.DEPTH(64), .STARVE_LIMIT(4)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .mem_rdata            (mem_rdata),
        .mem_en               (mem_en),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .ahb_grant            (ahb_grant),
        .ahb_wait             (ahb_wait),
        .usb_grant            (usb_grant),
        .rx_data              (rx_data),
        .rx_data_valid        (rx_data_valid),
        .tx_packet_data       (tx_packet_data),
        .tx_data_valid        (tx_data_valid),
        .buffer_occupancy     (buffer_occupancy),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM, read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    // Read-port scoreboard
    always @(negedge clk) begin
        if (rx_data_valid) begin
            checks++;
            if (rx_exp.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: rx_data_valid with rx_data=%0h, none expected", rx_data);
            end else begin
                mon_b = rx_exp.pop_front();
                if (rx_data !== mon_b) begin
                    errors++;
                    $display("FAIL rx_data: got %0h expected %0h", rx_data, mon_b);
                end
            end
        end
        if (tx_data_valid) begin
            checks++;
            if (tx_exp.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: tx_data_valid with tx_packet_data=%0h, none expected", tx_packet_data);
            end else begin
                mon_b = tx_exp.pop_front();
                if (tx_packet_data !== mon_b) begin
                    errors++;
                    $display("FAIL tx_data: got %0h expected %0h", tx_packet_data, mon_b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // FIFO reference model
    function automatic void m_write(input logic [7:0] b);
        if (model_q.size() < 64) begin
            model_q.push_back(b);
            exp_wr = (exp_wr + 1) % 64;
        end
    endfunction

    function automatic logic [7:0] m_read();
        if (model_q.size() == 0) return 8'h00;
        exp_rd = (exp_rd + 1) % 64;
        return model_q.pop_front();
    endfunction

    function automatic void m_clear();
        model_q.delete();
        exp_wr = 0;
        exp_rd = 0;
    endfunction

    // One cycle of stimulus: drive after the rising edge, return at the falling edge
    task automatic drive(input logic s_tx, input logic g_rx, input logic s_rx,
                         input logic g_tx, input logic clr,
                         input logic [7:0] txd, input logic [7:0] rxd);
        @(posedge clk);
        #1;
        store_tx_data        = s_tx;
        get_rx_data          = g_rx;
        store_rx_packet_data = s_rx;
        get_tx_packet_data   = g_tx;
        clear                = clr;
        tx_data              = txd;
        rx_packet_data       = rxd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        clear = 1'b0; store_tx_data = 1'b0; get_rx_data = 1'b0;
        store_rx_packet_data = 1'b0; get_tx_packet_data = 1'b0;
        tx_data = 8'h00; rx_packet_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, mem_we, ahb_grant, ahb_wait, usb_grant} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, ahb_grant, ahb_wait, usb_grant});
        end
        checks++;
        if ({rx_data_valid, tx_data_valid, overflow_err, underflow_err, buffer_occupancy} !== 11'b0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 0", {rx_data_valid, tx_data_valid, overflow_err, underflow_err, buffer_occupancy});
        end
        checks++;
        if ({rx_data, tx_packet_data, mem_addr, mem_wdata} !== 30'b0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {rx_data, tx_packet_data, mem_addr, mem_wdata});
        end
        n_rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bytes[i], 8'h00);
            checks++;
            if ({ahb_grant, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 6'(i), bytes[i]}) begin
                errors++;
                $display("FAIL basic_store: got %h expected %h", {ahb_grant, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 6'(i), bytes[i]});
            end
            m_write(bytes[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
            if (i == 0) begin
                checks++;
                if (buffer_occupancy !== 7'd3) begin
                    errors++;
                    $display("FAIL basic_occ3: got %0d expected 3", buffer_occupancy);
                end
            end
            checks++;
            if ({usb_grant, mem_en, mem_we, mem_addr} !== {3'b110, 6'(i)}) begin
                errors++;
                $display("FAIL basic_fetch: got %h expected %h", {usb_grant, mem_en, mem_we, mem_addr}, {3'b110, 6'(i)});
            end
            tx_exp.push_back(m_read());
        end
        idle();
        checks++;
        if ({tx_data_valid, buffer_occupancy} !== {1'b1, 7'd0}) begin
            errors++;
            $display("FAIL basic_last: got valid=%b occ=%0d expected valid=1 occ=0", tx_data_valid, buffer_occupancy);
        end
    endtask

    task automatic test_starve();
        logic ahb_exp;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'(16 + k));
            ahb_exp = (k == 5);
            checks++;
            if ({ahb_grant, usb_grant, ahb_wait} !== {ahb_exp, !ahb_exp, !ahb_exp}) begin
                errors++;
                $display("FAIL starve_cycle%0d: got ahb/usb/wait=%b expected %b", k, {ahb_grant, usb_grant, ahb_wait}, {ahb_exp, !ahb_exp, !ahb_exp});
            end
            if (ahb_exp) rx_exp.push_back(m_read());
            else         m_write(8'(16 + k));
        end
        idle();
        checks++;
        if (buffer_occupancy !== 7'(model_q.size())) begin
            errors++;
            $display("FAIL starve_occ: got %0d expected %0d", buffer_occupancy, model_q.size());
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'(32 + i));
            m_write(8'(32 + i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        tx_exp.push_back(m_read());
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A);
        checks++;
        if ({usb_grant, ahb_grant, mem_en, buffer_occupancy} !== {3'b000, 7'd10}) begin
            errors++;
            $display("FAIL clear_cycle: got grants/en=%b occ=%0d expected 000 occ=10", {usb_grant, ahb_grant, mem_en}, buffer_occupancy);
        end
        m_clear();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A);
        checks++;
        if ({usb_grant, mem_en, mem_we, mem_addr, buffer_occupancy} !== {3'b111, 6'd0, 7'd0}) begin
            errors++;
            $display("FAIL clear_after: got %h expected %h", {usb_grant, mem_en, mem_we, mem_addr, buffer_occupancy}, {3'b111, 6'd0, 7'd0});
        end
        m_write(8'h5A);
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 1; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), 8'h00);
            checks++;
            if ({ahb_grant, mem_en, mem_we, mem_addr} !== {3'b111, 6'(exp_wr)}) begin
                errors++;
                $display("FAIL fill_%0d: got %h expected %h", i, {ahb_grant, mem_en, mem_we, mem_addr}, {3'b111, 6'(exp_wr)});
            end
            m_write(8'(i));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 8'h00);
        checks++;
        if ({ahb_grant, mem_en, buffer_occupancy} !== {2'b10, 7'd64}) begin
            errors++;
            $display("FAIL full_write: got grant/en=%b occ=%0d expected 10 occ=64", {ahb_grant, mem_en}, buffer_occupancy);
        end
        m_write(8'hEE);
        idle();
        checks++;
        if ({overflow_err, buffer_occupancy} !== {1'b1, 7'd64}) begin
            errors++;
            $display("FAIL overflow_pulse: got ovf=%b occ=%0d expected ovf=1 occ=64", overflow_err, buffer_occupancy);
        end
        idle();
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_once: got %b expected 0", overflow_err);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if ({usb_grant, mem_en, mem_addr} !== {2'b11, 6'(exp_rd)}) begin
            errors++;
            $display("FAIL full_read: got %h expected %h", {usb_grant, mem_en, mem_addr}, {2'b11, 6'(exp_rd)});
        end
        tx_exp.push_back(m_read());
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77);
        checks++;
        if ({usb_grant, mem_en, mem_we, mem_addr} !== {3'b111, 6'd0}) begin
            errors++;
            $display("FAIL wrap_write: got %h expected %h", {usb_grant, mem_en, mem_we, mem_addr}, {3'b111, 6'd0});
        end
        m_write(8'h77);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
            checks++;
            if ({usb_grant, mem_en, mem_we, mem_addr} !== {3'b110, 6'(exp_rd)}) begin
                errors++;
                $display("FAIL drain_%0d: got %h expected %h", i, {usb_grant, mem_en, mem_we, mem_addr}, {3'b110, 6'(exp_rd)});
            end
            tx_exp.push_back(m_read());
        end
        idle();
        checks++;
        if (buffer_occupancy !== 7'd0) begin
            errors++;
            $display("FAIL drain_occ: got %0d expected 0", buffer_occupancy);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if ({ahb_grant, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL empty_read: got grant/en=%b expected 10", {ahb_grant, mem_en});
        end
        rx_exp.push_back(m_read());
        idle();
        checks++;
        if ({rx_data_valid, underflow_err, rx_data} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL underflow_pulse: got %h expected %h", {rx_data_valid, underflow_err, rx_data}, {2'b11, 8'h00});
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00);
        m_write(8'h3C);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if ({ahb_grant, mem_en, mem_addr} !== {2'b11, 6'(exp_rd)}) begin
            errors++;
            $display("FAIL rd_ptr_kept: got %h expected %h", {ahb_grant, mem_en, mem_addr}, {2'b11, 6'(exp_rd)});
        end
        rx_exp.push_back(m_read());
        idle();
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 8'h00);
        m_write(8'h99);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if ({ahb_grant, mem_en} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_grant: got %b expected 11", {ahb_grant, mem_en});
        end
        n_rst = 1'b0;
        get_rx_data = 1'b0;
        #1;
        checks++;
        if ({mem_en, ahb_grant, usb_grant, ahb_wait, rx_data_valid, tx_data_valid,
             overflow_err, underflow_err, buffer_occupancy, rx_data, tx_packet_data} !== 30'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 0", {mem_en, ahb_grant, usb_grant, ahb_wait, rx_data_valid,
                     tx_data_valid, overflow_err, underflow_err, buffer_occupancy, rx_data, tx_packet_data});
        end
        m_clear();
        @(negedge clk);
        checks++;
        if (rx_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got rx_data_valid=%b expected 0", rx_data_valid);
        end
        n_rst = 1'b1;
        idle();
        checks++;
        if ({rx_data_valid, buffer_occupancy} !== 8'b0) begin
            errors++;
            $display("FAIL post_reset: got valid=%b occ=%0d expected 0", rx_data_valid, buffer_occupancy);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC7);
        checks++;
        if ({usb_grant, mem_en, mem_addr} !== {2'b11, 6'd0}) begin
            errors++;
            $display("FAIL post_reset_write: got %h expected %h", {usb_grant, mem_en, mem_addr}, {2'b11, 6'd0});
        end
        m_write(8'hC7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rx_exp.push_back(m_read());
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_starve();
        test_clear();
        test_overflow();
        test_underflow();
        test_reset_mid_access();
        idle();
        idle();
        checks++;
        if ((rx_exp.size() + tx_exp.size()) != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d bytes never returned, expected 0", rx_exp.size() + tx_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
